// File: rtl/d20_pkg.sv
// Shared types, table geometry and arithmetic helpers for the d20 roll block.
package d20_pkg;

    localparam int FACES       = 20;
    localparam int TABLE_DEPTH = 32;
    localparam int ENTRY_W     = 5;
    localparam int MAX_W       = 16;

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef logic [ENTRY_W-1:0] ptr_t;
    typedef logic signed [MAX_W:0] wide_t;

    // (e % 20) + 1 for a 5-bit entry: a single conditional subtract suffices.
    function automatic entry_t face_of(input entry_t e);
        return (e >= entry_t'(FACES)) ? e - entry_t'(FACES - 1) : e + entry_t'(1);
    endfunction

    // Sum at the widest legal width, then clamp to the nbits signed range.
    function automatic wide_t sat_add(input entry_t face, input wide_t mod, input int nbits);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        sum = wide_t'({{(MAX_W + 1 - ENTRY_W){1'b0}}, face}) + mod;
        hi  = (wide_t'(1) <<< (nbits - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (nbits - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/d20_if.sv
// Load/roll bus of the d20 block: table write stream, roll controls and result.
interface d20_if #(parameter int NUM_BITS = 8);

    logic                       write;
    logic [4:0]                 data;
    logic [31:0]                addr;
    logic                       next;
    logic signed [NUM_BITS-1:0] mod;
    logic signed [NUM_BITS-1:0] target;
    logic [4:0]                 random_num;
    logic signed [NUM_BITS-1:0] final_num;
    logic                       hit;

    modport master (
        output write, data, addr, next, mod, target,
        input  random_num, final_num, hit
    );

    modport slave (
        input  write, data, addr, next, mod, target,
        output random_num, final_num, hit
    );

endinterface

// File: rtl/d20_roll_table.sv
// 32x5 register file, synchronous write and asynchronous read; never reset.
module d20_roll_table
    import d20_pkg::*;
(
    input  logic   clk,
    input  logic   we_i,
    input  ptr_t   waddr_i,
    input  entry_t wdata_i,
    input  ptr_t   raddr_i,
    output entry_t rdata_o
);

    entry_t mem_q [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/d20_top.sv
// d20 roll: table entry -> face 1..20, saturating add of mod, hit test vs target.
// Outputs registered: 1 cycle from mod/target/table, 2 cycles from a next rising edge.
module d20_top
    import d20_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    d20_if.slave bus
);

    ptr_t                       rd_ptr_q;
    ptr_t                       rd_ptr_d;
    logic                       next_q;
    logic                       write_q;
    logic                       advance;
    logic                       write_fall;
    entry_t                     entry;
    entry_t                     face;
    wide_t                      mod_ext;
    wide_t                      sum_sat;
    logic signed [NUM_BITS-1:0] final_d;
    logic                       hit_d;
    entry_t                     random_num_q;
    logic signed [NUM_BITS-1:0] final_num_q;
    logic                       hit_q;
    logic                       unused_hi;

    d20_roll_table u_table (
        .clk     (clk),
        .we_i    (bus.write),
        .waddr_i (bus.addr[4:0]),
        .wdata_i (bus.data),
        .raddr_i (rd_ptr_q),
        .rdata_o (entry)
    );

    assign write_fall = write_q & ~bus.write;
    assign advance    = bus.next & ~next_q & ~bus.write;

    // Loading (or just finished loading) pins the pointer to entry 0.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (bus.write || write_fall) begin
            rd_ptr_d = '0;
        end else if (advance) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
    end

    always_comb begin
        face    = face_of(entry);
        mod_ext = {{(MAX_W + 1 - NUM_BITS){bus.mod[NUM_BITS-1]}}, bus.mod};
        sum_sat = sat_add(face, mod_ext, NUM_BITS);
        final_d = sum_sat[NUM_BITS-1:0];
        hit_d   = 1'b0;
        if (face == entry_t'(FACES)) begin
            hit_d = 1'b1;
        end else if (face != entry_t'(1)) begin
            hit_d = (final_d >= bus.target);
        end
    end

    assign unused_hi = ^{bus.addr[31:5], sum_sat[MAX_W:NUM_BITS]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            next_q       <= 1'b0;
            write_q      <= 1'b0;
            random_num_q <= entry_t'(1);
            final_num_q  <= '0;
            hit_q        <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            next_q       <= bus.next;
            write_q      <= bus.write;
            random_num_q <= face;
            final_num_q  <= final_d;
            hit_q        <= hit_d;
        end
    end

    assign bus.random_num = random_num_q;
    assign bus.final_num  = final_num_q;
    assign bus.hit        = hit_q;

endmodule

// File: tb/tb_d20_top.sv
// Bench for d20_top: directed scenarios plus a randomized run against a cycle model.
module tb_d20_top;

    localparam int NB  = 8;
    localparam int SHI = 127;
    localparam int SLO = -128;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    // Reference model state
    int m_tbl [32];
    int m_ptr;
    int m_next_q;
    int m_write_q;
    int exp_rn;
    int exp_fn;
    int exp_hit;

    d20_if #(.NUM_BITS(NB)) bus ();

    d20_top #(.NUM_BITS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the model computes what the outputs must become at this edge.
    task automatic tick();
        int face;
        int sum;
        int md;
        int tg;
        md = int'(bus.mod);
        tg = int'(bus.target);
        if (!reset) begin
            exp_rn    = 1;
            exp_fn    = 0;
            exp_hit   = 0;
            m_ptr     = 0;
            m_next_q  = 0;
            m_write_q = 0;
        end else begin
            face = (m_tbl[m_ptr] % 20) + 1;
            sum  = face + md;
            if (sum > SHI) sum = SHI;
            if (sum < SLO) sum = SLO;
            exp_rn  = face;
            exp_fn  = sum;
            exp_hit = (face == 20) ? 1 : (face == 1) ? 0 : (sum >= tg) ? 1 : 0;
            if (bus.write || m_write_q != 0) m_ptr = 0;
            else if (bus.next && m_next_q == 0) m_ptr = (m_ptr + 1) % 32;
            m_next_q  = int'(bus.next);
            m_write_q = int'(bus.write);
        end
        if (bus.write) m_tbl[bus.addr % 32] = int'(bus.data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_next();
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        compared += 3;
        if (bus.random_num !== 5'd1) begin
            mismatched++;
            $display("FAIL reset_rn: got %0d want 1", bus.random_num);
        end
        if (bus.final_num !== 8'sd0) begin
            mismatched++;
            $display("FAIL reset_fn: got %0d want 0", bus.final_num);
        end
        if (bus.hit !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hit: got %b want 0", bus.hit);
        end
    endtask

    task automatic test_load();
        int init [5] = '{9, 19, 14, 0, 25};
        reset     = 1'b1;
        bus.write = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.addr = 32'(i) | ({$urandom} << 5);
            bus.data = (i < 5) ? 5'(init[i]) : 5'($urandom_range(0, 31));
            tick();
        end
        bus.write  = 1'b0;
        bus.mod    = 8'sd5;
        bus.target = 8'sd10;
        tick();
        tick();
        compared += 3;
        if (bus.random_num !== 5'd10) begin
            mismatched++;
            $display("FAIL load_rn: got %0d want 10", bus.random_num);
        end
        if (bus.final_num !== 8'sd15) begin
            mismatched++;
            $display("FAIL load_fn: got %0d want 15", bus.final_num);
        end
        if (bus.hit !== 1'b1) begin
            mismatched++;
            $display("FAIL load_hit: got %b want 1", bus.hit);
        end
    endtask

    task automatic test_rolls();
        bus.mod    = -8'sd3;
        bus.target = 8'sd0;
        pulse_next();
        compared += 3;
        if (bus.random_num !== 5'd20) begin
            mismatched++;
            $display("FAIL nat20_rn: got %0d want 20", bus.random_num);
        end
        if (bus.final_num !== 8'sd17) begin
            mismatched++;
            $display("FAIL nat20_fn: got %0d want 17", bus.final_num);
        end
        if (bus.hit !== 1'b1) begin
            mismatched++;
            $display("FAIL nat20_hit: got %b want 1", bus.hit);
        end
        bus.mod = -8'sd30;
        tick();
        compared += 2;
        if (bus.final_num !== -8'sd10) begin
            mismatched++;
            $display("FAIL nat20_neg_fn: got %0d want -10", bus.final_num);
        end
        if (bus.hit !== 1'b1) begin
            mismatched++;
            $display("FAIL nat20_neg_hit: got %b want 1", bus.hit);
        end
        bus.mod    = 8'sd0;
        bus.target = 8'sd15;
        pulse_next();
        compared += 2;
        if (bus.random_num !== 5'd15 || bus.final_num !== 8'sd15) begin
            mismatched++;
            $display("FAIL face15: got rn=%0d fn=%0d want 15/15", bus.random_num, bus.final_num);
        end
        if (bus.hit !== 1'b1) begin
            mismatched++;
            $display("FAIL eq_target_hit: got %b want 1", bus.hit);
        end
        bus.target = 8'sd16;
        tick();
        compared++;
        if (bus.hit !== 1'b0) begin
            mismatched++;
            $display("FAIL above_target_hit: got %b want 0", bus.hit);
        end
        bus.mod    = 8'sd7;
        bus.target = -8'sd5;
        pulse_next();
        compared += 3;
        if (bus.random_num !== 5'd1) begin
            mismatched++;
            $display("FAIL fumble_rn: got %0d want 1", bus.random_num);
        end
        if (bus.final_num !== 8'sd8) begin
            mismatched++;
            $display("FAIL fumble_fn: got %0d want 8", bus.final_num);
        end
        if (bus.hit !== 1'b0) begin
            mismatched++;
            $display("FAIL fumble_hit: got %b want 0", bus.hit);
        end
        pulse_next();
        compared++;
        if (bus.random_num !== 5'd6) begin
            mismatched++;
            $display("FAIL wrap_entry_rn: got %0d want 6", bus.random_num);
        end
    endtask

    task automatic test_saturation();
        bus.write = 1'b1;
        bus.addr  = 32'd0;
        bus.data  = 5'd14;
        bus.mod   = 8'sd127;
        tick();
        bus.write = 1'b0;
        tick();
        compared += 2;
        if (bus.random_num !== 5'd15) begin
            mismatched++;
            $display("FAIL sat_hi_rn: got %0d want 15", bus.random_num);
        end
        if (bus.final_num !== 8'sd127) begin
            mismatched++;
            $display("FAIL sat_hi_fn: got %0d want 127", bus.final_num);
        end
        bus.write = 1'b1;
        bus.data  = 5'd1;
        bus.mod   = 8'h80;
        tick();
        bus.write = 1'b0;
        tick();
        compared += 2;
        if (bus.random_num !== 5'd2) begin
            mismatched++;
            $display("FAIL sat_lo_rn: got %0d want 2", bus.random_num);
        end
        if (bus.final_num !== -8'sd126) begin
            mismatched++;
            $display("FAIL sat_lo_fn: got %0d want -126", bus.final_num);
        end
    endtask

    task automatic test_wrap();
        pulse_next();
        compared++;
        if (bus.random_num !== 5'd20) begin
            mismatched++;
            $display("FAIL wrap_first_rn: got %0d want 20", bus.random_num);
        end
        for (int i = 0; i < 31; i++) pulse_next();
        compared++;
        if (bus.random_num !== 5'd2 || bus.final_num !== -8'sd126) begin
            mismatched++;
            $display("FAIL wrap32: got rn=%0d fn=%0d want 2/-126", bus.random_num, bus.final_num);
        end
    endtask

    task automatic test_held_next();
        bus.next = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.next = 1'b0;
        tick();
        compared++;
        if (bus.random_num !== 5'd20) begin
            mismatched++;
            $display("FAIL held_next_rn: got %0d want 20", bus.random_num);
        end
    endtask

    task automatic test_write_edge_wins();
        bus.write = 1'b1;
        bus.addr  = 32'd0;
        bus.data  = 5'd1;
        tick();
        bus.write = 1'b0;
        bus.next  = 1'b1;
        tick();
        bus.next = 1'b0;
        tick();
        tick();
        compared++;
        if (bus.random_num !== 5'd2) begin
            mismatched++;
            $display("FAIL write_edge_wins_rn: got %0d want 2", bus.random_num);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 39) != 0);
            bus.write  = ($urandom_range(0, 7) == 0);
            bus.addr   = $urandom;
            bus.data   = 5'($urandom_range(0, 31));
            bus.next   = 1'($urandom_range(0, 1));
            bus.mod    = 8'($urandom_range(0, 255));
            bus.target = 8'($urandom_range(0, 255));
            tick();
            compared++;
            if (bus.random_num !== 5'(exp_rn) || bus.final_num !== 8'(exp_fn)
                || bus.hit !== 1'(exp_hit)) begin
                mismatched++;
                $display("FAIL random[%0d]: got rn=%0d fn=%0d hit=%b want rn=%0d fn=%0d hit=%0d",
                         i, bus.random_num, bus.final_num, bus.hit, exp_rn, exp_fn, exp_hit);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        foreach (m_tbl[i]) m_tbl[i] = 0;
        m_ptr      = 0;
        m_next_q   = 0;
        m_write_q  = 0;
        reset      = 1'b0;
        bus.write  = 1'b0;
        bus.data   = '0;
        bus.addr   = '0;
        bus.next   = 1'b0;
        bus.mod    = '0;
        bus.target = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_rolls();
        test_saturation();
        test_wrap();
        test_held_next();
        test_write_edge_wins();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
